// File: rtl/ram_pkg.sv
// Shared encodings for the ram_wait memory model (state, op, counter width).
// Optional byte enables are controlled by the RAM_WAIT_BE_EN macro.
package ram_pkg;

  localparam int WAIT_CNT_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Index width for a word array of the given depth; never zero.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_wait_if.sv
// CPU-side bus of ram_wait: address, request strobes, write/read data and ready.
// The be byte-enable lane exists only when RAM_WAIT_BE_EN is defined.
interface ram_wait_if #(
  parameter int DW = 16,
  parameter int AW = 16
);

  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] data;
  logic          RAM_ready;
`ifdef RAM_WAIT_BE_EN
  logic [DW/8-1:0] be;
`endif

  modport master (
    output
`ifdef RAM_WAIT_BE_EN
      be,
`endif
      addr, rd, wr, wdata,
    input  data, RAM_ready
  );

  modport slave (
    input
`ifdef RAM_WAIT_BE_EN
      be,
`endif
      addr, rd, wr, wdata,
    output data, RAM_ready
  );

endinterface

// File: rtl/ram_array.sv
// DW x DEPTH word storage: synchronous byte-masked write, range-checked read.
// Byte enables come from ram_wait (all ones unless RAM_WAIT_BE_EN is defined).
module ram_array
  import ram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  output logic [DW-1:0]   rdata
);

  localparam int unsigned IW = idx_width(DEPTH);
  localparam int unsigned BW = DW / 8;

  logic [DW-1:0] mem [DEPTH];
  logic          hit;
  logic [IW-1:0] idx;

  // DEPTH need not be a power of two, so the range check is an explicit compare.
  always_comb begin
    hit = ({1'b0, addr} < (AW + 1)'(DEPTH));
    idx = addr[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (we && hit) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (wbe[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) rdata = mem[idx];
  end

endmodule

// File: rtl/ram_wait.sv
// Single-port RAM with programmable wait states and a RAM_ready handshake.
// Define RAM_WAIT_BE_EN to add per-byte write enables on the bus.
module ram_wait
  import ram_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  ram_wait_if.slave  bus
);

  localparam int BW = DW / 8;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("ram_wait: WAIT_CYCLES must be in 0..255");
  end
  if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
    $error("ram_wait: DW must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || (AW < 31 && DEPTH > (1 << AW))) begin : g_bad_depth
    $error("ram_wait: DEPTH must be in 1..2**AW");
  end

  logic [0:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  op_q, op_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  ready_q, ready_d;

  logic [BW-1:0]         req_be;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [BW-1:0]         mem_be;
  logic [DW-1:0]         mem_rdata;

`ifdef RAM_WAIT_BE_EN
  always_comb req_be = bus.be;
`else
  always_comb req_be = '1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    data_d    = data_q;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_be    = be_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rd || bus.wr) begin
          op_d    = bus.wr ? OP_WR : OP_RD;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            // Zero-wait access bypasses the request registers and completes on this edge.
            mem_addr  = bus.addr;
            mem_wdata = bus.wdata;
            mem_be    = req_be;
            if (bus.wr) mem_we = 1'b1;
            else        data_d = mem_rdata;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (op_q == OP_WR) mem_we = 1'b1;
          else               data_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  ram_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .wbe   (mem_be),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus.data      = data_q;
    bus.RAM_ready = ready_q;
  end

endmodule

// File: tb/tb_ram_wait.sv
// Directed bench for ram_wait: three instances (0, 3 and 4 wait states) with a
// reference memory and an expected-read queue. Byte-enable steps need RAM_WAIT_BE_EN.
module tb_ram_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;

  ram_wait_if #(.DW(16), .AW(16)) if0 ();
  ram_wait_if #(.DW(16), .AW(16)) if1 ();
  ram_wait_if #(.DW(16), .AW(16)) if2 ();

  ram_wait #(.DW(16), .AW(16), .DEPTH(64), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst0), .bus(if0));
  ram_wait #(.DW(16), .AW(16), .DEPTH(51), .WAIT_CYCLES(3)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  ram_wait #(.DW(16), .AW(16), .DEPTH(64), .WAIT_CYCLES(4)) u2 (.clk(clk), .rst(rst2), .bus(if2));

  int checks = 0;
  int errors = 0;

  logic [15:0] m    [3][64];
  logic [15:0] last [3];
  int          dep  [3] = '{64, 51, 64};
  int          wt   [3] = '{0, 3, 4};
  logic [15:0] exp_q [$];

  logic        rdy;
  logic [15:0] dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    case (k)
      0: begin
        if0.rd = r; if0.wr = w; if0.addr = a; if0.wdata = d;
`ifdef RAM_WAIT_BE_EN
        if0.be = be;
`endif
      end
      1: begin
        if1.rd = r; if1.wr = w; if1.addr = a; if1.wdata = d;
`ifdef RAM_WAIT_BE_EN
        if1.be = be;
`endif
      end
      default: begin
        if2.rd = r; if2.wr = w; if2.addr = a; if2.wdata = d;
`ifdef RAM_WAIT_BE_EN
        if2.be = be;
`endif
      end
    endcase
  endtask

  task automatic sample(input int k, output logic r, output logic [15:0] d);
    case (k)
      0:       begin r = if0.RAM_ready; d = if0.data; end
      1:       begin r = if1.RAM_ready; d = if1.data; end
      default: begin r = if2.RAM_ready; d = if2.data; end
    endcase
  endtask

  // Reference effect of one accepted request; reads queue their expected data.
  task automatic model(input int k, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    logic [1:0] eb;
`ifdef RAM_WAIT_BE_EN
    eb = be;
`else
    eb = 2'b11;
`endif
    if (w) begin
      if (int'(a) < dep[k]) begin
        if (eb[0]) m[k][a][7:0]  = d[7:0];
        if (eb[1]) m[k][a][15:8] = d[15:8];
      end
    end else if (r) begin
      exp_q.push_back((int'(a) < dep[k]) ? m[k][a] : 16'h0000);
    end
  endtask

  // One full access: optional rd poke during the first wait cycle must be ignored.
  task automatic acc(input int k, input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] be, input logic poke);
    logic        rr;
    logic [15:0] dd;
    int          lows;
    @(negedge clk);
    drive(k, r, w, a, d, be);
    model(k, r, w, a, d, be);
    @(negedge clk);
    drive(k, poke, 1'b0, a + 16'd1, 16'hDEAD, be);
    sample(k, rr, dd);
    lows = 0;
    while (!rr && lows < 40) begin
      lows++;
      chk("data_hold", {16'h0, dd}, {16'h0, last[k]});
      @(negedge clk);
      drive(k, 1'b0, 1'b0, a, d, be);
      sample(k, rr, dd);
    end
    chk("ready_low_cycles", lows, wt[k]);
    if (r && !w) last[k] = exp_q.pop_front();
    chk("data", {16'h0, dd}, {16'h0, last[k]});
    @(negedge clk);
    sample(k, rr, dd);
    chk("no_queued_access", {31'h0, rr}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 1'b0, 16'h0, 16'h0, 2'b11);
      last[k] = 16'h0;
    end

    // Asynchronous reset before the first clock edge.
    #3;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      sample(k, rdy, dat);
      chk("reset_ready", {31'h0, rdy}, 32'h1);
      chk("reset_data", {16'h0, dat}, 32'h0);
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Zero wait states: back-to-back writes then reads, one request per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        sample(0, rdy, dat);
        chk("b2b_ready", {31'h0, rdy}, 32'h1);
        if (i > 2) last[0] = exp_q.pop_front();
        chk("b2b_data", {16'h0, dat}, {16'h0, last[0]});
      end
      case (i)
        0:       begin drive(0, 1'b0, 1'b1, 16'd0, 16'h2100, 2'b11); model(0, 1'b0, 1'b1, 16'd0, 16'h2100, 2'b11); end
        1:       begin drive(0, 1'b0, 1'b1, 16'd1, 16'hFF00, 2'b11); model(0, 1'b0, 1'b1, 16'd1, 16'hFF00, 2'b11); end
        2:       begin drive(0, 1'b1, 1'b0, 16'd0, 16'h0000, 2'b11); model(0, 1'b1, 1'b0, 16'd0, 16'h0000, 2'b11); end
        3:       begin drive(0, 1'b1, 1'b0, 16'd1, 16'h0000, 2'b11); model(0, 1'b1, 1'b0, 16'd1, 16'h0000, 2'b11); end
        default: drive(0, 1'b0, 1'b0, 16'd0, 16'h0000, 2'b11);
      endcase
    end
    chk("b2b_value", {16'h0, last[0]}, 32'h0000FF00);

    // Mid-cycle reset clears data without a clock edge.
    @(negedge clk);
    #2 rst0 = 1'b1;
    #1 sample(0, rdy, dat);
    chk("midcycle_reset_ready", {31'h0, rdy}, 32'h1);
    chk("midcycle_reset_data", {16'h0, dat}, 32'h0);
    last[0] = 16'h0;
    @(negedge clk);
    rst0 = 1'b0;
    acc(0, 1'b1, 1'b0, 16'd1, 16'h0000, 2'b11, 1'b0);

    // Three wait states, out-of-range and rd+wr priority on the DEPTH=51 instance.
    acc(1, 1'b0, 1'b1, 16'd1,  16'hFF00, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b0, 16'd1,  16'h0000, 2'b11, 1'b1);
    acc(1, 1'b0, 1'b1, 16'd2,  16'h1357, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b1, 16'd2,  16'h00FF, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b0, 16'd2,  16'h0000, 2'b11, 1'b0);
    acc(1, 1'b0, 1'b1, 16'd60, 16'h1234, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b0, 16'd60, 16'h0000, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b0, 16'd50, 16'h0000, 2'b11, 1'b0);
    acc(1, 1'b1, 1'b0, 16'd1,  16'h0000, 2'b11, 1'b0);

    // Four wait states: reset during the second wait cycle aborts the write.
    acc(2, 1'b0, 1'b1, 16'd3, 16'h1111, 2'b11, 1'b0);
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 16'd3, 16'h5555, 2'b11);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 16'd0, 16'h0000, 2'b11);
    @(negedge clk);
    #1 rst2 = 1'b1;
    #1 sample(2, rdy, dat);
    chk("abort_reset_ready", {31'h0, rdy}, 32'h1);
    chk("abort_reset_data", {16'h0, dat}, 32'h0);
    last[2] = 16'h0;
    @(negedge clk);
    rst2 = 1'b0;
    acc(2, 1'b1, 1'b0, 16'd3, 16'h0000, 2'b11, 1'b0);
    chk("abort_keeps_old", {16'h0, last[2]}, 32'h00001111);

`ifdef RAM_WAIT_BE_EN
    acc(2, 1'b0, 1'b1, 16'd3, 16'hAABB, 2'b01, 1'b0);
    acc(2, 1'b1, 1'b0, 16'd3, 16'h0000, 2'b00, 1'b0);
    chk("be_low_byte", {16'h0, last[2]}, 32'h000011BB);
    acc(2, 1'b0, 1'b1, 16'd3, 16'h7777, 2'b00, 1'b0);
    acc(2, 1'b1, 1'b0, 16'd3, 16'h0000, 2'b11, 1'b0);
`endif

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_wait.md
Name: ram_wait

Overview:
- Parametrised single-port RAM model with a ready handshake; the successor of the fixed, always-ready instruction/data memory that feeds `cpu`.
- Supports reads and writes, configurable data/address width and depth, and programmable wait states driving `RAM_ready`.
- Sits between the `cpu` bus (`addr`, `data`, `RAM_ready`) and on-chip storage, in both benches and synthesis.

Parameters:
- DW, 16, data width in bits; a multiple of 8.
- AW, 16, address width in bits; word addressing.
- DEPTH, 64, number of words; need not be a power of 2; DEPTH <= 2**AW.
- WAIT_CYCLES, 0, cycles `RAM_ready` stays low per access; range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- addr  input  AW  word address.
- rd  input  1  read request.
- wr  input  1  write request.
- wdata  input  DW  write data.
- data  output  DW  read data (registered).
- RAM_ready  output  1  high = idle and able to accept a request; low = access in progress.

Behaviour:
- Reset (async, any time, including mid-access):
  - State goes to IDLE, `RAM_ready`=1, `data`=0, wait counter cleared.
  - Any pending write is aborted; the array is not written.
  - Array contents are not cleared.
- FSM states are IDLE and WAIT.
- IDLE, rd|wr sampled high at a clk edge (accept edge): latch addr, wdata and op into request registers.
  - WAIT_CYCLES=0: the op executes on the accept edge, `data` is valid the next cycle (read latency 1), state stays IDLE, `RAM_ready` stays 1, back-to-back accesses every cycle.
  - WAIT_CYCLES=N>0: state goes to WAIT, counter loads N, `RAM_ready`=0 from the cycle after the accept edge.
- WAIT: the counter decrements each edge.
  - On the edge where the counter goes 1->0, the op executes using the latched addr/wdata, `data` updates (reads only), state returns to IDLE and `RAM_ready`=1.
  - `RAM_ready` is low for exactly N cycles. Total read latency is N+1 edges from accept.
- Requests in WAIT are ignored; they are not queued. addr/rd/wr/wdata changing during WAIT has no effect.
- rd and wr both high: write has priority, no read is performed, `data` holds its value.
- Writes never change `data`. There is no write-through.
- Out of range (addr >= DEPTH): reads return 0; writes are dropped. The access still takes N+1 edges and `RAM_ready` toggles normally.
- `data` holds its last read value until the next completed read or reset.
- Counter width is 8 bits; WAIT_CYCLES > 255 is an elaboration error.

Optional Feature:
- Macro: RAM_WAIT_BE_EN.
- Defined:
  - Adds port `be`, input, DW/8 bits, byte enables latched with wdata at accept.
  - On write, only bytes with `be`[i]=1 are updated; `be`=0 makes the write a no-op that still takes full latency.
  - Reads ignore `be`.
- Undefined: no `be` port; every write updates the full word.

Decomposition:
- Package `ram_pkg`:
  - state encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1.
  - WAIT_CNT_W=8.
  - Op encoding OP_RD=1'b0, OP_WR=1'b1.
- Sub-module `ram_array`:
  - Plain storage, DW x DEPTH.
  - One synchronous write port with byte-enable input (tied all-ones when the macro is off).
  - One synchronous read port with range check returning 0.
- `ram_wait` holds the FSM, counter, request registers and the `RAM_ready`/`data` output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> `RAM_ready`=1 and `data`=0 immediately, before any clk edge.
- WAIT_CYCLES=0: write 16'h2100 @0, 16'hFF00 @1, then read @0, @1 on consecutive cycles -> `data`=2100 then FF00 one cycle after each read; `RAM_ready` never low.
- WAIT_CYCLES=3: read @1 -> `RAM_ready` low for exactly 3 cycles, `data`=FF00 on the edge where `RAM_ready` rises; a second rd pulse during WAIT is ignored, with no extra access.
- Simultaneous rd=wr=1 @2 with wdata=00FF -> mem[2]=00FF and `data` unchanged; a later read @2 returns 00FF.
- Out of range (DEPTH=51): write 1234 @60, then read @60 -> `data`=0 and mem unchanged; `RAM_ready` toggles with normal latency.
- Reset mid-WAIT: WAIT_CYCLES=4, write 5555 @3, assert rst in the 2nd wait cycle -> mem[3] keeps its old value and `RAM_ready`=1. With RAM_WAIT_BE_EN: write AABB with be=2'b01 over 1111 -> 11BB.
